mov_engine: RTL and testbench

MOV_ENGINE -- requirements
Module: mov_engine

---
 rtl/mov_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_mov_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mov_engine.sv
// rtl/mov_engine.sv - tiny move engine: program memory, local registers, output FIFO
module mov_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NLocal             = 8,
  parameter int NProg              = 16,
  parameter int NOut               = 4,
  parameter int MaxSteps           = 1000,
  localparam int AW = (NLocal > 1) ? $clog2(NLocal) : 1,
  localparam int PW = (NProg > 1) ? $clog2(NProg) : 1,
  localparam int IW = 2 + AW + MemoryElementWidth
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          load_valid,
  input  logic [PW-1:0]                 load_addr,
  input  logic [IW-1:0]                 load_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MemoryElementWidth-1:0] out_data,
  output logic                          busy,
  output logic                          finished,
  output logic                          success,
  output logic [15:0]                   steps
);

  localparam int MW  = MemoryElementWidth;
  localparam int CW  = $clog2(NOut + 1);
  localparam int OPW = (NOut > 1) ? $clog2(NOut) : 1;

  localparam logic [PW:0]     IP_END    = (PW + 1)'(NProg);
  localparam logic [AW:0]     NLOC      = (AW + 1)'(NLocal);
  localparam logic [CW-1:0]   NOUT_C    = CW'(NOut);
  localparam logic [OPW-1:0]  OPTR_LAST = OPW'(NOut - 1);
  localparam logic [31:0]     MAX_STEPS = 32'(MaxSteps);

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_OUT  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Reset asserts immediately but is only released on a clock edge.
  logic [1:0] rst_sync;
  logic       rstn;

  // Program store survives reset, so it has no reset branch.
  logic [IW-1:0] prog_mem [2**PW];

  // Local registers are padded to a power of two so any index decodes safely.
  logic [MW-1:0] local_mem [2**AW];

  logic [PW:0]   ip;
  logic [PW:0]   ip_next;

  logic [MW-1:0] fifo_mem [NOut];
  logic [OPW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [IW-1:0] instr;
  logic [1:0]    opcode;
  logic [AW-1:0] dst;
  logic [MW-1:0] operand;
  logic [AW-1:0] src;
  logic          dst_bad, src_bad;

  logic [31:0]   steps_plus;
  logic          timeout;
  logic          start;
  logic          fifo_full;
  logic          push, pop;
  logic [MW-1:0] push_data;

  logic          exe_halt, exe_fault, exe_fall;
  logic          ip_inc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;

  // Two-flop reset synchronizer: async assert, clocked release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rstn = rst_sync[1];

  // Instruction fetch and field decode.
  assign instr   = prog_mem[ip[PW-1:0]];
  assign opcode  = instr[IW-1 -: 2];
  assign dst     = instr[MW +: AW];
  assign operand = instr[MW-1:0];
  assign src     = operand[AW-1:0];
  assign dst_bad = {1'b0, dst} >= NLOC;
  assign src_bad = {1'b0, src} >= NLOC;

  assign ip_next    = ip + 1'b1;
  assign steps_plus = {16'd0, steps} + 32'd1;
  // This EXEC cycle is the one that brings steps up to the limit.
  assign timeout    = steps_plus >= MAX_STEPS;
  assign start      = (state != S_EXEC) && run;
  assign fifo_full  = (count == NOUT_C);
  assign pop        = out_valid && out_ready;
  assign push_data  = local_mem[dst];

  // Instruction execution: decides writes, pushes, ip advance and exit cause.
  always_comb begin
    exe_halt  = 1'b0;
    exe_fault = 1'b0;
    exe_fall  = 1'b0;
    ip_inc    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = dst;
    mem_wdata = operand;
    push      = 1'b0;
    if (state == S_EXEC && !timeout) begin
      if (ip >= IP_END) begin
        exe_fall = 1'b1;
      end else begin
        case (opcode)
          OP_MOVI: begin
            if (dst_bad) begin
              exe_fault = 1'b1;
            end else begin
              mem_we = 1'b1;
              ip_inc = 1'b1;
            end
          end
          OP_MOV: begin
            if (dst_bad || src_bad) begin
              exe_fault = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = local_mem[src];
              ip_inc    = 1'b1;
            end
          end
          OP_OUT: begin
            if (dst_bad) begin
              exe_fault = 1'b1;
            end else if (!fifo_full) begin
              push   = 1'b1;
              ip_inc = 1'b1;
            end
          end
          default: begin
            exe_halt = 1'b1;
          end
        endcase
        if (ip_inc && ip_next == IP_END) exe_fall = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (run) state_next = S_EXEC;
      S_EXEC: if (timeout || exe_halt || exe_fault || exe_fall) state_next = S_DONE;
      S_DONE: if (run) state_next = S_EXEC;
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    busy     = (state == S_EXEC);
    finished = (state == S_DONE);
  end

  // Program loads are accepted only while the engine is not executing.
  always_ff @(posedge clock) begin
    if (load_valid && state != S_EXEC) prog_mem[load_addr] <= load_data;
  end

  // Execution context: ip, step counter, halt flag and local registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ip      <= '0;
      steps   <= '0;
      success <= 1'b0;
      for (int i = 0; i < 2**AW; i++) local_mem[i] <= '0;
    end else if (start) begin
      ip      <= '0;
      steps   <= '0;
      success <= 1'b0;
      for (int i = 0; i < 2**AW; i++) local_mem[i] <= '0;
    end else if (state == S_EXEC) begin
      if (steps != 16'hFFFF) steps <= steps + 16'd1;
      if (ip_inc)            ip <= ip_next;
      if (mem_we)            local_mem[mem_waddr] <= mem_wdata;
      if (exe_halt)          success <= 1'b1;
    end
  end

  // FIFO storage; entries are only meaningful while counted, so no reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy; pops are honoured in every state.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == OPTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == OPTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_mov_engine.sv
// tb/tb_mov_engine.sv - scoreboard bench for mov_engine
module tb_mov_engine;

  localparam int MW = 12;
  localparam int AW = 3;
  localparam int PW = 4;
  localparam int IW = 2 + AW + MW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          load_valid;
  logic [PW-1:0] load_addr;
  logic [IW-1:0] load_data;

  logic          run_a, out_ready_a, out_valid_a, busy_a, finished_a, success_a;
  logic [MW-1:0] out_data_a;
  logic [15:0]   steps_a;

  logic          run_b, out_ready_b, out_valid_b, busy_b, finished_b, success_b;
  logic [MW-1:0] out_data_b;
  logic [15:0]   steps_b;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_q [$];

  // Main instance: six local words (non-power-of-two), two-deep FIFO.
  mov_engine #(
    .MemoryElementWidth(MW), .NLocal(6), .NProg(16), .NOut(2), .MaxSteps(1000)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .run(run_a),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .busy(busy_a), .finished(finished_a), .success(success_a), .steps(steps_a)
  );

  // Timeout instance: MaxSteps of eight.
  mov_engine #(
    .MemoryElementWidth(MW), .NLocal(8), .NProg(16), .NOut(2), .MaxSteps(8)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .run(run_b),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .busy(busy_b), .finished(finished_b), .success(success_b), .steps(steps_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [1:0] op, input logic [2:0] d,
                                        input logic [11:0] v);
    return {op, d, v};
  endfunction

  // Scoreboard: every word leaving u_a must match the oldest expected word.
  always @(negedge clock) begin
    if (reset_n && out_valid_a && out_ready_a) begin
      if (exp_q.size() == 0) check("out_extra", 32'(out_data_a), 32'hFFFF_FFFF);
      else                   check("out_data", 32'(out_data_a), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    load_valid = 1'b1;
    load_addr  = PW'(addr);
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_prog1();
    load(0, ins(2'b00, 3'd0, 12'd1));
    load(1, ins(2'b00, 3'd1, 12'd2));
    load(2, ins(2'b00, 3'd2, 12'd3));
    load(3, ins(2'b10, 3'd0, 12'd0));
    load(4, ins(2'b10, 3'd1, 12'd0));
    load(5, ins(2'b10, 3'd2, 12'd0));
    load(6, ins(2'b11, 3'd0, 12'd0));
  endtask

  task automatic push_123();
    exp_q.push_back(12'd1);
    exp_q.push_back(12'd2);
    exp_q.push_back(12'd3);
  endtask

  task automatic pulse_run_a();
    run_a = 1'b1;
    tick();
    run_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!finished_a && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(finished_a), 32'd1);
  endtask

  task automatic wait_steps_a(input int target);
    int n = 0;
    while (steps_a != 16'(target) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("steps_reach", 32'(steps_a), 32'(target));
  endtask

  task automatic drain_check(input string tag);
    repeat (4) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n     = 1'b1;
    run_a       = 1'b0;
    run_b       = 1'b0;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    load_valid  = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_finished", 32'(finished_a), 32'd0);
    check("rst_success", 32'(success_a), 32'd0);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_steps", 32'(steps_a), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Basic program, consumer always ready.
    load_prog1();
    out_ready_a = 1'b1;
    push_123();
    pulse_run_a();
    wait_done_a("p1_done");
    check("p1_success", 32'(success_a), 32'd1);
    check("p1_steps", 32'(steps_a), 32'd7);
    check("p1_busy", 32'(busy_a), 32'd0);
    drain_check("p1_drain");

    // Backpressure: third out stalls on a full FIFO; a load during EXEC is ignored.
    out_ready_a = 1'b0;
    push_123();
    pulse_run_a();
    wait_steps_a(10);
    check("bp_busy", 32'(busy_a), 32'd1);
    check("bp_valid", 32'(out_valid_a), 32'd1);
    tick();
    out_ready_a = 1'b1;
    load_valid  = 1'b1;
    load_addr   = PW'(6);
    load_data   = ins(2'b00, 3'd0, 12'd5);
    tick();
    load_valid  = 1'b0;
    wait_done_a("bp_done");
    check("bp_success", 32'(success_a), 32'd1);
    check("bp_steps", 32'(steps_a), 32'd14);
    drain_check("bp_drain");

    // Fall off the end: every slot holds a movi.
    for (int i = 0; i < 16; i++) load(i, ins(2'b00, 3'(i % 6), 12'(i)));
    pulse_run_a();
    wait_done_a("fall_done");
    check("fall_success", 32'(success_a), 32'd0);
    check("fall_steps", 32'(steps_a), 32'd16);

    // Reset mid-run, then rerun the same program from ip 0.
    load_prog1();
    pulse_run_a();
    wait_steps_a(3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_finished", 32'(finished_a), 32'd0);
    check("mid_rst_success", 32'(success_a), 32'd0);
    check("mid_rst_steps", 32'(steps_a), 32'd0);
    check("mid_rst_valid", 32'(out_valid_a), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    push_123();
    pulse_run_a();
    wait_done_a("rerun_done");
    check("rerun_success", 32'(success_a), 32'd1);
    check("rerun_steps", 32'(steps_a), 32'd7);
    drain_check("rerun_drain");

    // Source index equal to NLocal faults.
    load(0, ins(2'b00, 3'd3, 12'd7));
    load(1, ins(2'b10, 3'd3, 12'd0));
    load(2, ins(2'b01, 3'd0, 12'd6));
    load(3, ins(2'b11, 3'd0, 12'd0));
    exp_q.push_back(12'd7);
    pulse_run_a();
    wait_done_a("src_fault_done");
    check("src_fault_success", 32'(success_a), 32'd0);
    check("src_fault_steps", 32'(steps_a), 32'd3);
    drain_check("src_fault_drain");

    // Rerun must see local memory cleared.
    load(0, ins(2'b10, 3'd3, 12'd0));
    load(1, ins(2'b11, 3'd0, 12'd0));
    exp_q.push_back(12'd0);
    pulse_run_a();
    wait_done_a("clear_done");
    check("clear_success", 32'(success_a), 32'd1);
    check("clear_steps", 32'(steps_a), 32'd2);
    drain_check("clear_drain");

    // Destination index equal to NLocal faults.
    load(0, ins(2'b00, 3'd6, 12'd1));
    pulse_run_a();
    wait_done_a("dst_fault_done");
    check("dst_fault_success", 32'(success_a), 32'd0);
    check("dst_fault_steps", 32'(steps_a), 32'd1);

    // Timeout on u_b with the consumer stalled; FIFO keeps 1,2.
    load_prog1();
    run_b = 1'b1;
    tick();
    run_b = 1'b0;
    n = 0;
    while (!finished_b && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("to_done", 32'(finished_b), 32'd1);
    check("to_success", 32'(success_b), 32'd0);
    check("to_steps", 32'(steps_b), 32'd8);
    check("to_valid", 32'(out_valid_b), 32'd1);
    check("to_head0", 32'(out_data_b), 32'd1);
    tick();
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    check("to_head1", 32'(out_data_b), 32'd2);
    check("to_valid1", 32'(out_valid_b), 32'd1);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    check("to_empty", 32'(out_valid_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
